ex_muldiv_seq: RTL

Sequencer for the RV32M multiply/divide unit that sits beside the EX-stage ALU. It accepts an M-extension operation whose operands have already passed through the EX forwarding muxes. It runs a shared iterative shift-add/restoring-divide datapath for that operation. It also holds the pipeline with a stall until the result is ready, then presents the result for the EX result mux. A kill input aborts an in-flight operation when the pipeline flushes.

---
 rtl/ex_muldiv_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer beside the EX-stage ALU: iterative shift-add / restoring divide.
// Optional `MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle 33x33 signed multiplier.
module ex_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        kill_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic        accept, a_signed, b_signed, a_neg, b_neg;
  logic        div_zero, div_ovf, fast_mul;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh;
  logic [63:0] prod_s;
  logic [31:0] res_calc;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_prod;
`endif

  always_comb begin
    accept   = (state_q == IDLE) && start_i && !kill_i;
    a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    a_neg    = a_signed && a_i[31];
    b_neg    = b_signed && b_i[31];
    a_mag    = a_neg ? (32'd0 - a_i) : a_i;
    b_mag    = b_neg ? (32'd0 - b_i) : b_i;
    div_zero = op_i[2] && (b_i == 32'd0);
    div_ovf  = ((op_i == 3'd4) || (op_i == 3'd6)) &&
               (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
    fast_mul  = !op_i[2];
    fast_prod = $signed({a_signed & a_i[31], a_i}) * $signed({b_signed & b_i[31], b_i});
`else
    fast_mul  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      op_q      <= 3'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      opnd_q    <= 32'd0;
      result_q  <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (div_zero || div_ovf || fast_mul) ? DONE : CALC;
      CALC:    if (count_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // hi/lo hold product or remainder/quotient; special cases preload both so DONE selects uniformly
  always_comb begin
    count_d   = count_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh    = {hi_q, lo_q[31]};
    if (accept) begin
      op_d      = op_i;
      count_d   = 5'd0;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      hi_d      = 32'd0;
      if (div_zero) begin
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
        lo_d      = 32'hFFFF_FFFF;
        hi_d      = a_i;
      end else if (div_ovf) begin
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
        lo_d      = 32'h8000_0000;
      end else if (fast_mul) begin
        neg_quo_d = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        {hi_d, lo_d} = fast_prod[63:0];
`endif
      end else if (op_i[2]) begin
        lo_d   = a_mag;
        opnd_d = b_mag;
      end else begin
        lo_d   = b_mag;
        opnd_d = a_mag;
      end
    end else if (state_q == CALC) begin
      count_d = count_q + 5'd1;
      if (!op_q[2]) begin
        hi_d = mul_sum[32:1];
        lo_d = {mul_sum[0], lo_q[31:1]};
      end else if (rem_sh >= {1'b0, opnd_q}) begin
        hi_d = rem_sh[31:0] - opnd_q;
        lo_d = {lo_q[30:0], 1'b1};
      end else begin
        hi_d = rem_sh[31:0];
        lo_d = {lo_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_s = neg_quo_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
    case (op_q)
      3'd0:          res_calc = prod_s[31:0];
      3'd1, 3'd2, 3'd3: res_calc = prod_s[63:32];
      3'd4, 3'd5:    res_calc = neg_quo_q ? (32'd0 - lo_q) : lo_q;
      default:       res_calc = neg_rem_q ? (32'd0 - hi_q) : hi_q;
    endcase
    done_o   = (state_q == DONE);
    stall_o  = accept || (state_q == CALC);
    result_d = done_o ? res_calc : result_q;
    result_o = result_d;
  end

endmodule
